// File: rtl/m_id_stage_pkg.sv
// Shared decode definitions: op-class codes, opcode constants, immediate formats
// and the decoded bundle layout. Also used by the execute stage.
package m_id_stage_pkg;

    typedef enum logic [3:0] {
        OPC_NOP     = 4'd0,
        OPC_LUI     = 4'd1,
        OPC_AUIPC   = 4'd2,
        OPC_JAL     = 4'd3,
        OPC_JALR    = 4'd4,
        OPC_BRANCH  = 4'd5,
        OPC_LOAD    = 4'd6,
        OPC_STORE   = 4'd7,
        OPC_OPIMM   = 4'd8,
        OPC_OP      = 4'd9,
        OPC_SYSTEM  = 4'd10,
        OPC_ILLEGAL = 4'd11
    } op_class_e;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [3:0]  op;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        illegal;
    } id_bundle_t;

    function automatic imm_fmt_e imm_fmt_of(input op_class_e op);
        case (op)
            OPC_LUI, OPC_AUIPC:          return IMM_U;
            OPC_JAL:                     return IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM: return IMM_I;
            OPC_BRANCH:                  return IMM_B;
            OPC_STORE:                   return IMM_S;
            default:                     return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/m_id_stage_imm_gen.sv
// Combinational opcode classification and sign-extended immediate extraction.
module m_imm_gen
    import m_id_stage_pkg::*;
#(
    parameter bit ILLEGAL_AS_NOP = 1'b0
) (
    input  logic [31:0] w_inst,
    output logic [31:0] w_imm,
    output logic [3:0]  w_op,
    output logic        w_illegal
);

    op_class_e op_c;
    imm_fmt_e  fmt_c;
    logic      ill_c;

    always_comb begin
        op_c  = OPC_ILLEGAL;
        ill_c = 1'b0;
        case (w_inst[6:0])
            OPCODE_LUI:    op_c = OPC_LUI;
            OPCODE_AUIPC:  op_c = OPC_AUIPC;
            OPCODE_JAL:    op_c = OPC_JAL;
            OPCODE_JALR:   op_c = OPC_JALR;
            OPCODE_BRANCH: op_c = OPC_BRANCH;
            OPCODE_LOAD:   op_c = OPC_LOAD;
            OPCODE_STORE:  op_c = OPC_STORE;
            OPCODE_OPIMM:  op_c = OPC_OPIMM;
            OPCODE_OP:     op_c = OPC_OP;
            OPCODE_SYSTEM: op_c = OPC_SYSTEM;
            default:       ill_c = 1'b1;
        endcase
        if (w_inst[1:0] != 2'b11 || w_inst == '0) begin
            ill_c = 1'b1;
        end
        if (ill_c) begin
            op_c = ILLEGAL_AS_NOP ? OPC_NOP : OPC_ILLEGAL;
        end

        fmt_c = ill_c ? IMM_NONE : imm_fmt_of(op_c);
        case (fmt_c)
            IMM_I:   w_imm = {{20{w_inst[31]}}, w_inst[31:20]};
            IMM_S:   w_imm = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            IMM_B:   w_imm = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                              w_inst[30:25], w_inst[11:8], 1'b0};
            IMM_U:   w_imm = {w_inst[31:12], 12'b0};
            IMM_J:   w_imm = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                              w_inst[20], w_inst[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    assign w_op      = op_c;
    assign w_illegal = ill_c;

endmodule

// File: rtl/m_id_stage.sv
// Decode stage: one main entry driving the outputs plus one skid entry, so
// w_in_ready is a register with no combinational path from w_out_ready.
module m_id_stage
    import m_id_stage_pkg::*;
#(
    parameter bit ILLEGAL_AS_NOP = 1'b0
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_in_valid,
    input  logic [31:0] w_inst,
    input  logic [31:0] w_in_pc,
    output logic        w_in_ready,
    output logic [4:0]  w_rs1,
    output logic [4:0]  w_rs2,
    input  logic [31:0] w_rs1_val,
    input  logic [31:0] w_rs2_val,
    input  logic        w_flush,
    output logic        w_out_valid,
    input  logic        w_out_ready,
    output logic [31:0] r_out_pc,
    output logic [4:0]  r_rd,
    output logic [31:0] r_rs1_data,
    output logic [31:0] r_rs2_data,
    output logic [31:0] r_imm,
    output logic [3:0]  r_op,
    output logic [2:0]  r_funct3,
    output logic        r_funct7b5,
    output logic        r_illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKID
    } state_e;

    state_e     state_q;
    logic       in_ready_q;
    id_bundle_t main_q;
    id_bundle_t skid_q;
    id_bundle_t dec_d;

    logic [31:0] imm_w;
    logic [3:0]  op_w;
    logic        ill_w;
    logic        in_xfer;
    logic        out_xfer;

    m_imm_gen #(
        .ILLEGAL_AS_NOP(ILLEGAL_AS_NOP)
    ) u_imm_gen (
        .w_inst    (w_inst),
        .w_imm     (imm_w),
        .w_op      (op_w),
        .w_illegal (ill_w)
    );

    assign w_rs1 = w_inst[19:15];
    assign w_rs2 = w_inst[24:20];

    always_comb begin
        dec_d          = '0;
        dec_d.pc       = w_in_pc;
        dec_d.rs1_data = w_rs1_val;
        dec_d.rs2_data = w_rs2_val;
        dec_d.imm      = imm_w;
        dec_d.op       = op_w;
        dec_d.funct3   = w_inst[14:12];
        dec_d.funct7b5 = w_inst[30];
        dec_d.illegal  = ill_w;
        // rd is meaningless for anything that does not write back
        if (!(ill_w || op_w == OPC_BRANCH || op_w == OPC_STORE)) begin
            dec_d.rd = w_inst[11:7];
        end
    end

    assign w_in_ready  = in_ready_q;
    assign w_out_valid = (state_q != ST_EMPTY);
    assign in_xfer     = w_in_valid & in_ready_q;
    assign out_xfer    = w_out_valid & w_out_ready;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (w_flush) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_q  <= dec_d;
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= dec_d;
                    end else if (in_xfer) begin
                        skid_q     <= dec_d;
                        state_q    <= ST_SKID;
                        in_ready_q <= 1'b0;
                    end else if (out_xfer) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        main_q     <= skid_q;
                        state_q    <= ST_FULL;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign r_out_pc   = main_q.pc;
    assign r_rd       = main_q.rd;
    assign r_rs1_data = main_q.rs1_data;
    assign r_rs2_data = main_q.rs2_data;
    assign r_imm      = main_q.imm;
    assign r_op       = main_q.op;
    assign r_funct3   = main_q.funct3;
    assign r_funct7b5 = main_q.funct7b5;
    assign r_illegal  = main_q.illegal;

endmodule

// File: tb/tb_m_id_stage.sv
// Directed bench for m_id_stage: decode vector table plus skid, flush and reset sequences.
module tb_m_id_stage;
    import m_id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] inst, in_pc, rs1_val, rs2_val;
    logic        in_ready, out_valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] out_pc, rs1_data, rs2_data, imm;
    logic [3:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5, illegal;

    logic        n_in_ready, n_out_valid, n_funct7b5, n_illegal;
    logic [4:0]  n_rs1, n_rs2, n_rd;
    logic [31:0] n_out_pc, n_rs1_data, n_rs2_data, n_imm;
    logic [3:0]  n_op;
    logic [2:0]  n_funct3;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] seen_q[$];

    always #5 clk = ~clk;

    m_id_stage #(.ILLEGAL_AS_NOP(1'b0)) dut (
        .w_clk(clk), .w_rst(rst), .w_in_valid(in_valid), .w_inst(inst), .w_in_pc(in_pc),
        .w_in_ready(in_ready), .w_rs1(rs1), .w_rs2(rs2), .w_rs1_val(rs1_val),
        .w_rs2_val(rs2_val), .w_flush(flush), .w_out_valid(out_valid),
        .w_out_ready(out_ready), .r_out_pc(out_pc), .r_rd(rd), .r_rs1_data(rs1_data),
        .r_rs2_data(rs2_data), .r_imm(imm), .r_op(op), .r_funct3(funct3),
        .r_funct7b5(funct7b5), .r_illegal(illegal)
    );

    m_id_stage #(.ILLEGAL_AS_NOP(1'b1)) dut_nop (
        .w_clk(clk), .w_rst(rst), .w_in_valid(in_valid), .w_inst(inst), .w_in_pc(in_pc),
        .w_in_ready(n_in_ready), .w_rs1(n_rs1), .w_rs2(n_rs2), .w_rs1_val(rs1_val),
        .w_rs2_val(rs2_val), .w_flush(flush), .w_out_valid(n_out_valid),
        .w_out_ready(out_ready), .r_out_pc(n_out_pc), .r_rd(n_rd), .r_rs1_data(n_rs1_data),
        .r_rs2_data(n_rs2_data), .r_imm(n_imm), .r_op(n_op), .r_funct3(n_funct3),
        .r_funct7b5(n_funct7b5), .r_illegal(n_illegal)
    );

    // Bundles leaving the main DUT, identified by PC
    always @(posedge clk) begin
        if (!rst && !flush && out_valid && out_ready) seen_q.push_back(out_pc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        f7b5;
        logic        ill;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{32'h00510093, 32'd7,  32'd11, OPC_OPIMM,   5'd1, 5'd2,  5'd5,  32'h00000005, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{32'hFE208CE3, 32'd3,  32'd4,  OPC_BRANCH,  5'd0, 5'd1,  5'd2,  32'hFFFFFFF8, 3'd0, 1'b1, 1'b0};
        vecs[2]  = '{32'h123452B7, 32'hA,  32'hB,  OPC_LUI,     5'd5, 5'd8,  5'd3,  32'h12345000, 3'd5, 1'b0, 1'b0};
        vecs[3]  = '{32'h00000000, 32'h1,  32'h2,  OPC_ILLEGAL, 5'd0, 5'd0,  5'd0,  32'h00000000, 3'd0, 1'b0, 1'b1};
        vecs[4]  = '{32'h0020A423, 32'h100,32'h55, OPC_STORE,   5'd0, 5'd1,  5'd2,  32'h00000008, 3'd2, 1'b0, 1'b0};
        vecs[5]  = '{32'hFFDFF0EF, 32'h0,  32'h0,  OPC_JAL,     5'd1, 5'd31, 5'd29, 32'hFFFFFFFC, 3'd7, 1'b1, 1'b0};
        vecs[6]  = '{32'h402081B3, 32'h9,  32'h4,  OPC_OP,      5'd3, 5'd1,  5'd2,  32'h00000000, 3'd0, 1'b1, 1'b0};
        vecs[7]  = '{32'hFFC0A283, 32'h200,32'h0,  OPC_LOAD,    5'd5, 5'd1,  5'd28, 32'hFFFFFFFC, 3'd2, 1'b1, 1'b0};
        vecs[8]  = '{32'h00001317, 32'h0,  32'h0,  OPC_AUIPC,   5'd6, 5'd0,  5'd0,  32'h00001000, 3'd1, 1'b0, 1'b0};
        vecs[9]  = '{32'h00C100E7, 32'h40, 32'h0,  OPC_JALR,    5'd1, 5'd2,  5'd12, 32'h0000000C, 3'd0, 1'b0, 1'b0};
        vecs[10] = '{32'h00000073, 32'h0,  32'h0,  OPC_SYSTEM,  5'd0, 5'd0,  5'd0,  32'h00000000, 3'd0, 1'b0, 1'b0};
        vecs[11] = '{32'h00510090, 32'h7,  32'h0,  OPC_ILLEGAL, 5'd0, 5'd2,  5'd5,  32'h00000000, 3'd0, 1'b0, 1'b1};
        vecs[12] = '{32'h0000000F, 32'h0,  32'h0,  OPC_ILLEGAL, 5'd0, 5'd0,  5'd0,  32'h00000000, 3'd0, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        inst = '0; in_pc = '0; rs1_val = '0; rs2_val = '0;
        tick(); tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_fields", out_pc | rs1_data | rs2_data | imm |
            {rd, op, funct3, funct7b5, illegal}, 32'd0);
        rst = 1'b0;

        // Table: back-to-back accepts with downstream always ready
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            inst     = vecs[i].inst;
            in_pc    = 32'h10 + 32'(i) * 4;
            rs1_val  = vecs[i].rs1v;
            rs2_val  = vecs[i].rs2v;
            #1;
            chk($sformatf("v%0d_rs1", i), {27'b0, rs1}, {27'b0, vecs[i].rs1});
            chk($sformatf("v%0d_rs2", i), {27'b0, rs2}, {27'b0, vecs[i].rs2});
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            rs1_val  = 32'hDEADBEEF;
            rs2_val  = 32'hCAFEF00D;
            #1;
            chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("v%0d_pc", i), out_pc, 32'h10 + 32'(i) * 4);
            chk($sformatf("v%0d_op", i), {28'b0, op}, {28'b0, vecs[i].op});
            chk($sformatf("v%0d_rd", i), {27'b0, rd}, {27'b0, vecs[i].rd});
            chk($sformatf("v%0d_imm", i), imm, vecs[i].imm);
            chk($sformatf("v%0d_rs1d", i), rs1_data, vecs[i].rs1v);
            chk($sformatf("v%0d_rs2d", i), rs2_data, vecs[i].rs2v);
            chk($sformatf("v%0d_f3", i), {29'b0, funct3}, {29'b0, vecs[i].f3});
            chk($sformatf("v%0d_f7b5", i), {31'b0, funct7b5}, {31'b0, vecs[i].f7b5});
            chk($sformatf("v%0d_ill", i), {31'b0, illegal}, {31'b0, vecs[i].ill});
            chk($sformatf("v%0d_nop_op", i), {28'b0, n_op},
                {28'b0, vecs[i].ill ? OPC_NOP : vecs[i].op});
            chk($sformatf("v%0d_nop_ill", i), {31'b0, n_illegal}, {31'b0, vecs[i].ill});
            chk($sformatf("v%0d_nop_rd", i), {27'b0, n_rd}, {27'b0, vecs[i].rd});
        end
        tick();
        chk("drain_empty", {31'b0, out_valid}, 32'd0);

        // Back-pressure: A, B, C with downstream stalled
        seen_q.delete();
        out_ready = 1'b0;
        inst = 32'h00510093; rs1_val = 32'd1;
        in_valid = 1'b1; in_pc = 32'h100; tick();
        in_pc = 32'h104; rs1_val = 32'd2; tick();
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        in_pc = 32'h108; rs1_val = 32'd3;
        for (int i = 0; i < 3; i++) tick();
        chk("bp_hold_pc", out_pc, 32'h100);
        chk("bp_hold_rs1d", rs1_data, 32'd1);
        chk("bp_still_blocked", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 10 && !ok; i++) begin
                ok = in_ready;
                tick();
            end
            in_valid = 1'b0;
            chk("bp_c_accept_timeout", {31'b0, ok}, 32'd1);
        end
        for (int i = 0; i < 10 && out_valid; i++) tick();
        chk("bp_count", seen_q.size(), 32'd3);
        if (seen_q.size() == 3) begin
            chk("bp_order_a", seen_q[0], 32'h100);
            chk("bp_order_b", seen_q[1], 32'h104);
            chk("bp_order_c", seen_q[2], 32'h108);
        end

        // Flush while in SKID with a new instruction on offer
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h400; tick();
        in_pc = 32'h404; tick();
        chk("fl_skid_ready", {31'b0, in_ready}, 32'd0);
        flush = 1'b1; in_pc = 32'h408; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
        seen_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("fl_nothing_emitted", seen_q.size(), 32'd0);
        chk("fl_stays_empty", {31'b0, out_valid}, 32'd0);

        // Reset while FULL and stalled, then immediate accept
        out_ready = 1'b0;
        inst = 32'hFE208CE3; rs1_val = 32'h77;
        in_valid = 1'b1; in_pc = 32'h300; tick();
        in_valid = 1'b0;
        chk("rs_full", {31'b0, out_valid}, 32'd1);
        rst = 1'b1; tick();
        chk("rs_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rs_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rs_fields", out_pc | rs1_data | rs2_data | imm |
            {rd, op, funct3, funct7b5, illegal}, 32'd0);
        rst = 1'b0; in_valid = 1'b1; in_pc = 32'h304; tick();
        in_valid = 1'b0;
        chk("rs_first_accept", {31'b0, out_valid}, 32'd1);
        chk("rs_first_pc", out_pc, 32'h304);
        chk("rs_first_op", {28'b0, op}, {28'b0, OPC_BRANCH});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
